// File: rtl/rggen_counter_bit_field_pkg.sv
// Shared constants and types for the multi-channel counter bit field.
// Action codes match the values used across the rest of the register map.
package rggen_counter_bit_field_pkg;

    localparam int RGGEN_READ_NONE     = 0;
    localparam int RGGEN_READ_DEFAULT  = 1;
    localparam int RGGEN_READ_SET      = 2;
    localparam int RGGEN_READ_CLEAR    = 3;

    localparam int RGGEN_WRITE_NONE    = 0;
    localparam int RGGEN_WRITE_DEFAULT = 1;

    typedef struct packed {
        logic read;
        logic write;
    } sw_access_t;

endpackage

// File: rtl/rggen_counter_channel.sv
// One counter channel: value register, sticky overflow, threshold-crossing pulse.
// Priority: hw clear > sw write > read-clear (keeps same-cycle increment) > increment.
module rggen_counter_channel #(
    parameter int               WIDTH         = 16,
    parameter int               INC_WIDTH     = 4,
    parameter logic [WIDTH-1:0] INITIAL_VALUE = '0,
    parameter bit               SATURATE      = 1'b0
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_clear,
    input  logic                 i_write,
    input  logic [WIDTH-1:0]     i_write_mask,
    input  logic [WIDTH-1:0]     i_write_data,
    input  logic                 i_read_clear,
    input  logic                 i_inc_valid,
    input  logic [INC_WIDTH-1:0] i_inc_amount,
    input  logic [WIDTH-1:0]     i_threshold,
    output logic [WIDTH-1:0]     o_value,
    output logic                 o_overflow,
    output logic                 o_threshold_hit
);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_next;
    logic             overflow_q;
    logic             overflow_next;
    logic             hit_q;
    logic             hit_next;
    logic [WIDTH:0]   sum;
    logic             carry;
    logic [WIDTH-1:0] inc_next;

    always_comb begin
        sum           = {1'b0, value_q} + (WIDTH+1)'(i_inc_amount);
        carry         = sum[WIDTH];
        inc_next      = (SATURATE && carry) ? '1 : sum[WIDTH-1:0];
        value_next    = value_q;
        overflow_next = overflow_q;
        if (i_clear) begin
            value_next    = '0;
            overflow_next = 1'b0;
        end else if (i_write) begin
            value_next    = (value_q & ~i_write_mask) | (i_write_data & i_write_mask);
            overflow_next = 1'b0;
        end else if (i_read_clear) begin
            // The counter restarts from this cycle's increment so no event is lost
            value_next    = i_inc_valid ? WIDTH'(i_inc_amount) : '0;
            overflow_next = 1'b0;
        end else if (i_inc_valid) begin
            value_next    = inc_next;
            overflow_next = overflow_q | carry;
        end
        // A wrap lands below the old value, so it can never satisfy this crossing test
        hit_next = (i_threshold != '0) && (value_q < i_threshold) &&
                   (value_next >= i_threshold);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            value_q    <= INITIAL_VALUE;
            overflow_q <= 1'b0;
            hit_q      <= 1'b0;
        end else begin
            value_q    <= value_next;
            overflow_q <= overflow_next;
            hit_q      <= hit_next;
        end
    end

    assign o_value         = value_q;
    assign o_overflow      = overflow_q;
    assign o_threshold_hit = hit_q;

endmodule

// File: rtl/rggen_counter_bit_field.sv
// Packs CHANNELS independent hardware event counters into one register bit field.
// Software reads, read-clears or loads them; hardware increments by a variable amount.
module rggen_counter_bit_field
    import rggen_counter_bit_field_pkg::*;
#(
    parameter int               CHANNELS        = 4,
    parameter int               WIDTH           = 16,
    parameter int               INC_WIDTH       = 4,
    parameter logic [WIDTH-1:0] INITIAL_VALUE   = '0,
    parameter bit               SATURATE        = 1'b0,
    parameter int               SW_READ_ACTION  = RGGEN_READ_DEFAULT,
    parameter int               SW_WRITE_ACTION = RGGEN_WRITE_DEFAULT
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_sw_valid,
    input  logic [CHANNELS*WIDTH-1:0]     i_sw_read_mask,
    input  logic                          i_sw_write_enable,
    input  logic [CHANNELS*WIDTH-1:0]     i_sw_write_mask,
    input  logic [CHANNELS*WIDTH-1:0]     i_sw_write_data,
    output logic [CHANNELS*WIDTH-1:0]     o_sw_read_data,
    input  logic [CHANNELS-1:0]           i_hw_inc_valid,
    input  logic [CHANNELS*INC_WIDTH-1:0] i_hw_inc_amount,
    input  logic [CHANNELS-1:0]           i_hw_clear,
    input  logic [CHANNELS*WIDTH-1:0]     i_threshold,
    output logic [CHANNELS*WIDTH-1:0]     o_value,
    output logic [CHANNELS-1:0]           o_overflow,
    output logic [CHANNELS-1:0]           o_threshold_hit,
    output logic                          o_event
);

    localparam bit WRITABLE   = (SW_WRITE_ACTION == RGGEN_WRITE_DEFAULT);
    localparam bit READ_CLEAR = (SW_READ_ACTION == RGGEN_READ_CLEAR);
    localparam bit READABLE   = (SW_READ_ACTION != RGGEN_READ_NONE);

    for (genvar g = 0; g < CHANNELS; g++) begin : g_channel
        sw_access_t access;

        assign access.read  = i_sw_valid && (|i_sw_read_mask[g*WIDTH+:WIDTH]);
        assign access.write = WRITABLE && i_sw_valid && i_sw_write_enable &&
                              (|i_sw_write_mask[g*WIDTH+:WIDTH]);

        rggen_counter_channel #(
            .WIDTH         (WIDTH),
            .INC_WIDTH     (INC_WIDTH),
            .INITIAL_VALUE (INITIAL_VALUE),
            .SATURATE      (SATURATE)
        ) u_channel (
            .i_clk           (i_clk),
            .i_rst_n         (i_rst_n),
            .i_clear         (i_hw_clear[g]),
            .i_write         (access.write),
            .i_write_mask    (i_sw_write_mask[g*WIDTH+:WIDTH]),
            .i_write_data    (i_sw_write_data[g*WIDTH+:WIDTH]),
            .i_read_clear    (READ_CLEAR && access.read),
            .i_inc_valid     (i_hw_inc_valid[g]),
            .i_inc_amount    (i_hw_inc_amount[g*INC_WIDTH+:INC_WIDTH]),
            .i_threshold     (i_threshold[g*WIDTH+:WIDTH]),
            .o_value         (o_value[g*WIDTH+:WIDTH]),
            .o_overflow      (o_overflow[g]),
            .o_threshold_hit (o_threshold_hit[g])
        );

        // Read data is the value held during the access, before any read-clear lands
        assign o_sw_read_data[g*WIDTH+:WIDTH] = READABLE ? o_value[g*WIDTH+:WIDTH] : '0;
    end

    assign o_event = |o_threshold_hit;

endmodule
